alu_seq: RTL

Multi-cycle execution sequencer sitting directly downstream of the 8×8 register file. It accepts one operation at a time via a start/busy handshake and drives the file's read selects (`asel`/`bsel`). It computes on the returned `aout`/`bout`, then writes the result back through `csel`/`cload`/`cin`. Single-cycle ALU ops complete in 2 cycles; MUL uses an 8-step shift-add loop.

---
 rtl/alu_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU sequencer driving an 8x8 register file
module alu_seq (
  input  logic       clk,
  input  logic       clrn,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [2:0] rd,
  input  logic [2:0] rs,
  input  logic [2:0] rt,
  input  logic [7:0] aout,
  input  logic [7:0] bout,
  output logic [2:0] asel,
  output logic [2:0] bsel,
  output logic [2:0] csel,
  output logic       cload,
  output logic [7:0] cin,
  output logic       busy,
  output logic       done,
  output logic       zf,
  output logic       cf
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_MUL, S_WRITE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_r;
  logic [7:0]  opa, opb, result;
  logic [15:0] acc, acc_nxt;
  logic [2:0]  count;
  logic        res_cf;
  logic [8:0]  alu_wide;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    cload     = 1'b0;
    done      = 1'b0;
    cin       = 8'h00;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  state_nxt = (op_r == OP_MUL) ? S_MUL : S_WRITE;
      S_MUL:   if (count == 3'd7) state_nxt = S_WRITE;
      S_WRITE: begin
        cload     = 1'b1;
        done      = 1'b1;
        cin       = result;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle ops work straight off the read data; bit 8 carries carry/borrow.
  always_comb begin
    alu_wide = 9'h000;
    case (op_r)
      OP_ADD:  alu_wide = {1'b0, aout} + {1'b0, bout};
      OP_SUB:  alu_wide = {1'b0, aout} - {1'b0, bout};
      OP_AND:  alu_wide = {1'b0, aout & bout};
      OP_OR:   alu_wide = {1'b0, aout | bout};
      OP_XOR:  alu_wide = {1'b0, aout ^ bout};
      OP_SHL:  alu_wide = {aout, 1'b0};
      OP_MOV:  alu_wide = {1'b0, aout};
      default: alu_wide = 9'h000;
    endcase
  end

  always_comb begin
    acc_nxt = acc;
    if (opb[count]) acc_nxt = acc + ({8'h00, opa} << count);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      op_r   <= 3'd0;
      asel   <= 3'd0;
      bsel   <= 3'd0;
      csel   <= 3'd0;
      opa    <= 8'h00;
      opb    <= 8'h00;
      acc    <= 16'h0000;
      count  <= 3'd0;
      result <= 8'h00;
      res_cf <= 1'b0;
      zf     <= 1'b0;
      cf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_r <= op;
          csel <= rd;
          asel <= rs;
          bsel <= rt;
        end
        S_READ: begin
          opa <= aout;
          opb <= bout;
          if (op_r == OP_MUL) begin
            acc   <= 16'h0000;
            count <= 3'd0;
          end else begin
            result <= alu_wide[7:0];
            res_cf <= alu_wide[8];
          end
        end
        S_MUL: begin
          acc   <= acc_nxt;
          count <= count + 3'd1;
          if (count == 3'd7) begin
            result <= acc_nxt[7:0];
            res_cf <= |acc_nxt[15:8];
          end
        end
        S_WRITE: begin
          zf <= (result == 8'h00);
          cf <= res_cf;
        end
        default: ;
      endcase
    end
  end

endmodule
